// File: rtl/ebus_device_responder.sv
// -----------------------------------------------------------------------------
// ebus_device_responder
//
// Device-side EBUS slave for the KL10 I/O path.  One instance sits between the
// EBUS and a single peripheral core (DTE, timers, ...).  It answers the EBOX
// initiator for CONO / CONI / DATAO / DATAI on its own controller-select code,
// and for PI-served / PI-address-in cycles on its current PI level.  It returns
// ack and xfer and drives read data through its own tEBUSdriver slot.
//
// Optional build macro:
//   EBUS_PARITY_EN - when defined, ebusParity carries odd parity over the
//                    driven data word (registered with the data); when left
//                    undefined, ebusParity is tied to 0.
//
// Parameters:
//   DEV_CS     controller-select code this device answers to
//   XFER_DELAY cycles from ack rising to xfer rising (1..15)
//   IVEC       word driven on a PI-address-in cycle
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   ebusCs         [0:6] controller select from EBOX ([4:6] = PI level on PI cycles)
//   ebusFunc       bus function code
//   ebusDemand     EBOX demand
//   ebusReset      EBUS bus reset, synchronous to clk, overrides everything
//   ebusDataIn     [0:35] EBUS data as seen from the mux
//   ebusDriver     [0:36] {data[0:35], driving}
//   ebusAck        acknowledge
//   ebusXfer       transfer done
//   ebusPi         [0:7] PI request lines, bit piLevel raised on devPiReq
//   ebusParity     parity of driven data (see EBUS_PARITY_EN)
//   devConiIn      [0:32] device status bits returned by CONI
//   devDataIn      word returned by DATAI
//   devPiReq       device interrupt request
//   devConoOut     last CONO word
//   devConoStrobe  one-cycle pulse when devConoOut is written
//   devDataOut     last DATAO word
//   devDataoStrobe one-cycle pulse when devDataOut is written
//   devDataiStrobe one-cycle pulse; device may advance its read data
//   devPiServed    one-cycle pulse on a PI-served cycle
// -----------------------------------------------------------------------------
module ebus_device_responder #(
    parameter logic [0:6]  DEV_CS     = 7'o20,
    parameter int unsigned XFER_DELAY = 2,
    parameter logic [0:35] IVEC       = 36'o0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [0:6]  ebusCs,
    input  logic [2:0]  ebusFunc,
    input  logic        ebusDemand,
    input  logic        ebusReset,
    input  logic [0:35] ebusDataIn,
    output logic [0:36] ebusDriver,
    output logic        ebusAck,
    output logic        ebusXfer,
    output logic [0:7]  ebusPi,
    output logic        ebusParity,
    input  logic [0:32] devConiIn,
    input  logic [0:35] devDataIn,
    input  logic        devPiReq,
    output logic [0:35] devConoOut,
    output logic        devConoStrobe,
    output logic [0:35] devDataOut,
    output logic        devDataoStrobe,
    output logic        devDataiStrobe,
    output logic        devPiServed
);

    // Bus function encoding
    localparam logic [2:0] F_CONO   = 3'b000;
    localparam logic [2:0] F_CONI   = 3'b001;
    localparam logic [2:0] F_DATAO  = 3'b010;
    localparam logic [2:0] F_DATAI  = 3'b011;
    localparam logic [2:0] F_PISERV = 3'b100;
    localparam logic [2:0] F_PIADDR = 3'b101;

    // The counter is loaded on entry to ACK and expires at zero, so a load of
    // XFER_DELAY-1 puts xfer exactly XFER_DELAY cycles after ack.
    localparam logic [3:0] CNT_INIT = 4'(XFER_DELAY - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK  = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

    // Odd parity bit: makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [0:35] d);
        return ~(^d);
    endfunction

    // Functions for which this device drives the data word.
    function automatic logic is_read_func(input logic [2:0] f);
        return (f == F_CONI) || (f == F_DATAI) || (f == F_PIADDR);
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  func_q, func_d;
    logic [0:35] wdata_q, wdata_d;
    logic        armed_q, armed_d;
    logic [2:0]  pi_level_q, pi_level_d;
    logic        ack_q, ack_d;
    logic        xfer_q, xfer_d;
    logic        drv_q, drv_d;
    logic [0:35] rdata_q, rdata_d;
    logic [0:35] cono_q, cono_d;
    logic        cono_stb_q, cono_stb_d;
    logic [0:35] datao_q, datao_d;
    logic        datao_stb_q, datao_stb_d;
    logic        datai_stb_q, datai_stb_d;
    logic        pi_served_q, pi_served_d;

    logic        match_s;
    logic        accept_s;
    logic        enter_xfer_s;

    // Address/function match for the cycle presented on the bus.
    always_comb begin
        match_s = 1'b0;
        case (ebusFunc)
            F_CONO, F_CONI, F_DATAO, F_DATAI: match_s = (ebusCs == DEV_CS);
            F_PISERV, F_PIADDR: match_s = (ebusCs[4:6] == pi_level_q) &&
                                          (pi_level_q != 3'd0) && devPiReq;
            default: match_s = 1'b0;
        endcase
    end

    // A new cycle starts only from IDLE and only once demand has been seen low
    // since the previous cycle (armed), so a held demand never retriggers.
    assign accept_s = (state_q == ST_IDLE) && ebusDemand && armed_q && match_s;

    // Next-state logic: handshake sequencing, delay counter and command latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        wdata_d = wdata_q;

        if (!ebusDemand) begin
            armed_d = 1'b1;
        end else if (accept_s) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ACK;
                    cnt_d   = CNT_INIT;
                    func_d  = ebusFunc;
                    wdata_d = ebusDataIn;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK, ST_WAIT: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_XFER: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!ebusDemand) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign enter_xfer_s = (state_d == ST_XFER);

    // Output next-values, derived from the next state so every output is a flop.
    always_comb begin
        ack_d  = (state_d != ST_IDLE);
        xfer_d = (state_d == ST_XFER) || (state_d == ST_HOLD);
        drv_d  = xfer_d && is_read_func(func_q);

        // Read data is sampled once on the edge into XFER and held through HOLD.
        if (enter_xfer_s) begin
            case (func_q)
                F_CONI:   rdata_d = {devConiIn, pi_level_q};
                F_DATAI:  rdata_d = devDataIn;
                F_PIADDR: rdata_d = IVEC;
                default:  rdata_d = 36'o0;
            endcase
        end else if (state_d == ST_HOLD) begin
            rdata_d = rdata_q;
        end else begin
            rdata_d = 36'o0;
        end

        if (enter_xfer_s && (func_q == F_CONO)) begin
            cono_d     = wdata_q;
            pi_level_d = wdata_q[33:35];
            cono_stb_d = 1'b1;
        end else begin
            cono_d     = cono_q;
            pi_level_d = pi_level_q;
            cono_stb_d = 1'b0;
        end

        if (enter_xfer_s && (func_q == F_DATAO)) begin
            datao_d     = wdata_q;
            datao_stb_d = 1'b1;
        end else begin
            datao_d     = datao_q;
            datao_stb_d = 1'b0;
        end

        datai_stb_d = enter_xfer_s && (func_q == F_DATAI);
        pi_served_d = enter_xfer_s && (func_q == F_PISERV);
    end

    // State and output registers; bus reset clears everything including a live cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            func_q      <= 3'd0;
            wdata_q     <= 36'o0;
            armed_q     <= 1'b0;
            pi_level_q  <= 3'd0;
            ack_q       <= 1'b0;
            xfer_q      <= 1'b0;
            drv_q       <= 1'b0;
            rdata_q     <= 36'o0;
            cono_q      <= 36'o0;
            cono_stb_q  <= 1'b0;
            datao_q     <= 36'o0;
            datao_stb_q <= 1'b0;
            datai_stb_q <= 1'b0;
            pi_served_q <= 1'b0;
        end else if (ebusReset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            func_q      <= 3'd0;
            wdata_q     <= 36'o0;
            armed_q     <= 1'b0;
            pi_level_q  <= 3'd0;
            ack_q       <= 1'b0;
            xfer_q      <= 1'b0;
            drv_q       <= 1'b0;
            rdata_q     <= 36'o0;
            cono_q      <= 36'o0;
            cono_stb_q  <= 1'b0;
            datao_q     <= 36'o0;
            datao_stb_q <= 1'b0;
            datai_stb_q <= 1'b0;
            pi_served_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            wdata_q     <= wdata_d;
            armed_q     <= armed_d;
            pi_level_q  <= pi_level_d;
            ack_q       <= ack_d;
            xfer_q      <= xfer_d;
            drv_q       <= drv_d;
            rdata_q     <= rdata_d;
            cono_q      <= cono_d;
            cono_stb_q  <= cono_stb_d;
            datao_q     <= datao_d;
            datao_stb_q <= datao_stb_d;
            datai_stb_q <= datai_stb_d;
            pi_served_q <= pi_served_d;
        end
    end

`ifdef EBUS_PARITY_EN
    logic parity_q, parity_d;

    // Parity follows the data word into the same register stage.
    always_comb begin
        if (drv_d) begin
            parity_d = odd_parity(rdata_d);
        end else begin
            parity_d = 1'b0;
        end
    end

    // Parity register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            parity_q <= 1'b0;
        end else if (ebusReset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign ebusParity = parity_q;
`else
    assign ebusParity = 1'b0;
`endif

    // PI request fan-out: one line, selected by the registered level.
    always_comb begin
        ebusPi = 8'b0;
        if (devPiReq && (pi_level_q != 3'd0)) begin
            ebusPi[pi_level_q] = 1'b1;
        end else begin
            ebusPi = 8'b0;
        end
    end

    assign ebusDriver     = {rdata_q, drv_q};
    assign ebusAck        = ack_q;
    assign ebusXfer       = xfer_q;
    assign devConoOut     = cono_q;
    assign devConoStrobe  = cono_stb_q;
    assign devDataOut     = datao_q;
    assign devDataoStrobe = datao_stb_q;
    assign devDataiStrobe = datai_stb_q;
    assign devPiServed    = pi_served_q;

endmodule

// File: tb/tb_ebus_device_responder.sv
module tb_ebus_device_responder;

    localparam logic [2:0] F_CONO   = 3'b000;
    localparam logic [2:0] F_CONI   = 3'b001;
    localparam logic [2:0] F_DATAO  = 3'b010;
    localparam logic [2:0] F_DATAI  = 3'b011;
    localparam logic [2:0] F_PISERV = 3'b100;
    localparam logic [2:0] F_PIADDR = 3'b101;

    logic        clk;
    logic        resetN;
    logic [6:0]  ebusCs;
    logic [2:0]  ebusFunc;
    logic        ebusDemand;
    logic        ebusReset;
    logic [35:0] ebusDataIn;
    logic [36:0] ebusDriver;
    logic        ebusAck, ebusXfer, ebusParity;
    logic [7:0]  ebusPi;
    logic [32:0] devConiIn;
    logic [35:0] devDataIn;
    logic        devPiReq;
    logic [35:0] devConoOut, devDataOut;
    logic        devConoStrobe, devDataoStrobe, devDataiStrobe, devPiServed;

    // second instance with the minimum delay, same bus inputs
    logic [36:0] d1_driver;
    logic        d1_ack, d1_xfer, d1_parity;
    logic [7:0]  d1_pi;
    logic [35:0] d1_cono, d1_datao;
    logic        d1_cstb, d1_dostb, d1_distb, d1_pis;

    int checks = 0;
    int errors = 0;

    ebus_device_responder #(.DEV_CS(7'o20), .XFER_DELAY(2), .IVEC(36'o40)) dut (
        .clk(clk), .resetN(resetN), .ebusCs(ebusCs), .ebusFunc(ebusFunc),
        .ebusDemand(ebusDemand), .ebusReset(ebusReset), .ebusDataIn(ebusDataIn),
        .ebusDriver(ebusDriver), .ebusAck(ebusAck), .ebusXfer(ebusXfer),
        .ebusPi(ebusPi), .ebusParity(ebusParity), .devConiIn(devConiIn),
        .devDataIn(devDataIn), .devPiReq(devPiReq), .devConoOut(devConoOut),
        .devConoStrobe(devConoStrobe), .devDataOut(devDataOut),
        .devDataoStrobe(devDataoStrobe), .devDataiStrobe(devDataiStrobe),
        .devPiServed(devPiServed)
    );

    ebus_device_responder #(.DEV_CS(7'o20), .XFER_DELAY(1), .IVEC(36'o40)) dut1 (
        .clk(clk), .resetN(resetN), .ebusCs(ebusCs), .ebusFunc(ebusFunc),
        .ebusDemand(ebusDemand), .ebusReset(ebusReset), .ebusDataIn(ebusDataIn),
        .ebusDriver(d1_driver), .ebusAck(d1_ack), .ebusXfer(d1_xfer),
        .ebusPi(d1_pi), .ebusParity(d1_parity), .devConiIn(devConiIn),
        .devDataIn(devDataIn), .devPiReq(devPiReq), .devConoOut(d1_cono),
        .devConoStrobe(d1_cstb), .devDataOut(d1_datao),
        .devDataoStrobe(d1_dostb), .devDataiStrobe(d1_distb),
        .devPiServed(d1_pis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  func;
        logic [6:0]  cs;
        logic [35:0] wdata;
        logic [32:0] coni;
        logic [35:0] datai;
        logic        pireq;
        logic        exp_ack;
        logic        exp_drv;
        logic [35:0] exp_data;
        logic [3:0]  exp_stb;   // {cono, datao, datai, piserved}
        logic [7:0]  exp_pi;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    logic [35:0] model_cono;
    logic [35:0] model_datao;

    function automatic vec_t mk(input logic [2:0] f, input logic [6:0] cs,
                                input logic [35:0] wd, input logic [32:0] ci,
                                input logic [35:0] di, input logic pr,
                                input logic a, input logic dv, input logic [35:0] ed,
                                input logic [3:0] st, input logic [7:0] pi);
        vec_t v;
        v.func = f; v.cs = cs; v.wdata = wd; v.coni = ci; v.datai = di;
        v.pireq = pr; v.exp_ack = a; v.exp_drv = dv; v.exp_data = ed;
        v.exp_stb = st; v.exp_pi = pi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_parity(input logic dv, input logic [35:0] d);
`ifdef EBUS_PARITY_EN
        return dv ? ~(^d) : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Run one bus cycle with demand held 8 cycles, then release and check.
    task automatic do_vec(input vec_t v);
        int ack_k, xfer_k, xfer1_k;
        vec_t e;
        @(negedge clk);
        ebusFunc = v.func; ebusCs = v.cs; ebusDataIn = v.wdata;
        devConiIn = v.coni; devDataIn = v.datai; devPiReq = v.pireq;
        ebusDemand = 1'b1;
        if (v.exp_ack) sb_q.push_back(v);
        ack_k = 0; xfer_k = 0; xfer1_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ebusAck && ack_k == 0) ack_k = k;
            if (d1_xfer && xfer1_k == 0) xfer1_k = k;
            if (ebusXfer && xfer_k == 0) begin
                xfer_k = k;
                if (sb_q.size() == 0) begin
                    chk("unexpected_xfer", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_driver", {27'd0, ebusDriver}, {27'd0, e.exp_data, e.exp_drv});
                    chk("xfer_strobes", {60'd0, devConoStrobe, devDataoStrobe, devDataiStrobe, devPiServed},
                        {60'd0, e.exp_stb});
                    chk("xfer_parity", {63'd0, ebusParity}, {63'd0, exp_parity(e.exp_drv, e.exp_data)});
                    // device may change its read word right after the strobe
                    devDataIn = ~v.datai;
                    devConiIn = ~v.coni;
                end
            end else if (xfer_k != 0 && k == xfer_k + 1) begin
                chk("hold_driver", {27'd0, ebusDriver}, {27'd0, v.exp_data, v.exp_drv});
                chk("hold_ack_xfer", {62'd0, ebusAck, ebusXfer}, 64'd3);
                chk("hold_strobes_low", {60'd0, devConoStrobe, devDataoStrobe, devDataiStrobe, devPiServed}, 64'd0);
            end
        end
        chk("ack_cycle", 64'(ack_k), v.exp_ack ? 64'd1 : 64'd0);
        chk("xfer_cycle_d2", 64'(xfer_k), v.exp_ack ? 64'd3 : 64'd0);
        chk("xfer_cycle_d1", 64'(xfer1_k), v.exp_ack ? 64'd2 : 64'd0);
        ebusDemand = 1'b0;
        if (v.exp_ack && v.func == F_CONO) model_cono = v.wdata;
        if (v.exp_ack && v.func == F_DATAO) model_datao = v.wdata;
        @(negedge clk);
        chk("release_idle", {26'd0, ebusAck, ebusXfer, ebusDriver}, 64'd0);
        chk("pi_lines", {56'd0, ebusPi}, {56'd0, v.exp_pi});
        chk("cono_reg", {28'd0, devConoOut}, {28'd0, model_cono});
        chk("datao_reg", {28'd0, devDataOut}, {28'd0, model_datao});
    endtask

    initial begin
        int n;
        resetN = 1'b0; ebusReset = 1'b0; ebusDemand = 1'b0;
        ebusCs = 7'o0; ebusFunc = 3'd0; ebusDataIn = 36'o0;
        devConiIn = 33'o0; devDataIn = 36'o0; devPiReq = 1'b1;
        model_cono = 36'o0; model_datao = 36'o0;

        //       func      cs     wdata            coni    datai            pr    ack   drv   exp_data         stb      pi
        vecs.push_back(mk(F_CONO,   7'o20, 36'o5,            33'o0, 36'o0,            1'b1, 1'b1, 1'b0, 36'o0,            4'b1000, 8'b00000100));
        vecs.push_back(mk(F_DATAI,  7'o20, 36'o0,            33'o0, 36'o123456701234, 1'b1, 1'b1, 1'b1, 36'o123456701234, 4'b0010, 8'b00000100));
        vecs.push_back(mk(F_PIADDR, 7'o05, 36'o0,            33'o0, 36'o0,            1'b1, 1'b1, 1'b1, 36'o40,           4'b0000, 8'b00000100));
        vecs.push_back(mk(F_PIADDR, 7'o04, 36'o0,            33'o0, 36'o0,            1'b1, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00000100));
        vecs.push_back(mk(F_PISERV, 7'o15, 36'o0,            33'o0, 36'o0,            1'b1, 1'b1, 1'b0, 36'o0,            4'b0001, 8'b00000100));
        vecs.push_back(mk(F_CONO,   7'o20, 36'o3,            33'o0, 36'o0,            1'b0, 1'b1, 1'b0, 36'o0,            4'b1000, 8'b00000000));
        vecs.push_back(mk(F_CONI,   7'o20, 36'o0,            33'o1, 36'o0,            1'b1, 1'b1, 1'b1, 36'o13,           4'b0000, 8'b00010000));
        vecs.push_back(mk(F_DATAO,  7'o20, 36'o777000111222, 33'o0, 36'o0,            1'b0, 1'b1, 1'b0, 36'o0,            4'b0100, 8'b00000000));
        vecs.push_back(mk(F_CONO,   7'o21, 36'o7,            33'o0, 36'o0,            1'b1, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00010000));
        vecs.push_back(mk(3'b110,   7'o20, 36'o0,            33'o0, 36'o0,            1'b1, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00010000));
        vecs.push_back(mk(3'b111,   7'o23, 36'o0,            33'o0, 36'o0,            1'b1, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00010000));
        vecs.push_back(mk(F_PISERV, 7'o03, 36'o0,            33'o0, 36'o0,            1'b0, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00000000));
        vecs.push_back(mk(F_DATAI,  7'o20, 36'o0,            33'o0, 36'o1,            1'b0, 1'b1, 1'b1, 36'o1,            4'b0010, 8'b00000000));
        vecs.push_back(mk(F_DATAI,  7'o20, 36'o0,            33'o0, 36'o3,            1'b0, 1'b1, 1'b1, 36'o3,            4'b0010, 8'b00000000));
        vecs.push_back(mk(F_CONO,   7'o20, 36'o0,            33'o0, 36'o0,            1'b1, 1'b1, 1'b0, 36'o0,            4'b1000, 8'b00000000));
        vecs.push_back(mk(F_PIADDR, 7'o00, 36'o0,            33'o0, 36'o0,            1'b1, 1'b0, 1'b0, 36'o0,            4'b0000, 8'b00000000));

        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("reset_bus_outputs", {25'd0, ebusAck, ebusXfer, ebusParity, ebusDriver}, 64'd0);
        chk("reset_pi", {56'd0, ebusPi}, 64'd0);
        chk("reset_dev_outputs", {devConoOut, devConoStrobe, devDataoStrobe, devDataiStrobe, devPiServed},
            64'd0);
        chk("reset_datao", {28'd0, devDataOut}, 64'd0);

        foreach (vecs[i]) do_vec(vecs[i]);

        // Abort: DATAO with demand dropped right after ack.
        @(negedge clk);
        ebusFunc = F_DATAO; ebusCs = 7'o20; ebusDataIn = 36'o111; ebusDemand = 1'b1;
        @(negedge clk);
        chk("abort_ack", {63'd0, ebusAck}, 64'd1);
        ebusDemand = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ebusXfer || devDataoStrobe || d1_xfer || d1_dostb) n++;
        end
        chk("abort_no_xfer", 64'(n), 64'd0);
        chk("abort_ack_low", {63'd0, ebusAck}, 64'd0);
        chk("abort_datao_kept", {28'd0, devDataOut}, {28'd0, model_datao});

        // Bus reset during HOLD, then no retrigger while demand stays high.
        do_vec(mk(F_CONO, 7'o20, 36'o5, 33'o0, 36'o0, 1'b1, 1'b1, 1'b0, 36'o0, 4'b1000, 8'b00000100));
        @(negedge clk);
        ebusFunc = F_DATAI; ebusCs = 7'o20; devDataIn = 36'o42; ebusDemand = 1'b1;
        n = 0;
        for (int k = 0; k < 8 && !ebusXfer; k++) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_xfer", {63'd0, ebusXfer}, 64'd1);
        @(negedge clk);
        chk("rst_hold_driving", {27'd0, ebusDriver}, {27'd0, 36'o42, 1'b1});
        ebusReset = 1'b1;
        @(negedge clk);
        ebusReset = 1'b0;
        chk("rst_bus_outputs", {25'd0, ebusAck, ebusXfer, ebusParity, ebusDriver}, 64'd0);
        chk("rst_pi_zero", {56'd0, ebusPi}, 64'd0);
        chk("rst_cono_zero", {28'd0, devConoOut}, 64'd0);
        model_cono = 36'o0;
        model_datao = 36'o0;
        ebusFunc = F_CONO; ebusDataIn = 36'o6;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ebusAck) n++;
        end
        chk("no_retrigger", 64'(n), 64'd0);
        ebusDemand = 1'b0;
        do_vec(mk(F_CONO, 7'o20, 36'o6, 33'o0, 36'o0, 1'b1, 1'b1, 1'b0, 36'o0, 4'b1000, 8'b00000010));

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
